hs_responder: RTL and testbench

- Responder end of the four-phase req/ack handshake used by the controller FSM.
- Samples `req` and captures `req_data` into an internal FIFO, then raises `ack` and holds it until `req` falls.
- Drains captured data downstream over a valid/ready port.
- Exposes occupancy, stall and protocol-error status so formal properties (req→ack within 1–2 cycles, no overflow) can be checked directly on its ports.

---
 rtl/hs_responder_pkg.sv | 19 +
 rtl/hs_rsp_fifo.sv | 48 ++++
 rtl/hs_responder.sv | 128 ++++++++++++
 tb/tb_hs_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_responder_pkg.sv
// Shared types, default parameters and helpers for the hs_responder slice.
package hs_responder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        ACK_HIGH   = 2'b01,
        WAIT_SPACE = 2'b10
    } state_e;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 2;

    // Caller truncates to pointer width; modulo arithmetic makes the low bits exact.
    function automatic logic [31:0] fifo_level(input logic [31:0] wr, input logic [31:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/hs_rsp_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop frees space for a same-cycle push when full.
module hs_rsp_fifo
    import hs_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign level     = (ADDR_W+1)'(fifo_level(32'(r_wr_ptr), 32'(r_rd_ptr)));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
    end

endmodule

// File: rtl/hs_responder.sv
// Four-phase req/ack responder: captures req_data into a FIFO and drains it over valid/ready.
module hs_responder
    import hs_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic [7:0]        txn_count,
    output logic              stall_timeout,
    output logic              proto_err,
    input  logic              clr_err
);

    localparam int unsigned        STALL_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(ACK_TIMEOUT);

    state_e             r_state;
    logic               r_ack;
    logic               r_stall_timeout;
    logic               r_proto_err;
    logic [7:0]         r_txn_count;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_space;
    logic               w_push;

    // A full FIFO is never empty, so rsp_ready alone guarantees a same-cycle pop.
    assign w_pop       = ~w_empty & rsp_ready;
    assign w_space     = ~w_full | rsp_ready;
    assign w_push      = req & w_space & ((r_state == IDLE) || (r_state == WAIT_SPACE));
    assign w_stall_nxt = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + STALL_W'(1);

    hs_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (req_data),
        .dout  (rsp_data),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_ack           <= 1'b0;
            r_txn_count     <= '0;
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes precedence.
            if (clr_err) begin
                r_stall_timeout <= 1'b0;
                r_proto_err     <= 1'b0;
            end
            if (w_push) r_txn_count <= r_txn_count + 8'd1;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (w_space) begin
                            r_state <= ACK_HIGH;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state     <= WAIT_SPACE;
                            r_stall_cnt <= STALL_W'(1);
                            if (ACK_TIMEOUT <= 1) r_stall_timeout <= 1'b1;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (!req) begin
                        r_state     <= IDLE;
                        r_stall_cnt <= '0;
                        r_proto_err <= 1'b1;
                    end else if (w_space) begin
                        r_state     <= ACK_HIGH;
                        r_ack       <= 1'b1;
                        r_stall_cnt <= '0;
                    end else begin
                        r_stall_cnt <= w_stall_nxt;
                        if (w_stall_nxt == STALL_MAX) r_stall_timeout <= 1'b1;
                    end
                end
                ACK_HIGH: begin
                    if (!req) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign rsp_valid     = ~w_empty;
    assign full          = w_full;
    assign empty         = w_empty;
    assign txn_count     = r_txn_count;
    assign stall_timeout = r_stall_timeout;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_hs_responder.sv
// Self-checking bench for hs_responder: directed scenarios plus random traffic against a queue model.
module tb_hs_responder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int TO     = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              req       = 1'b0;
    logic              rsp_ready = 1'b0;
    logic              clr_err   = 1'b0;
    logic [DATA_W-1:0] req_data  = '0;
    logic              ack, rsp_valid, full, empty, stall_timeout, proto_err;
    logic [DATA_W-1:0] rsp_data;
    logic [7:0]        txn_count;
    logic [ADDR_W:0]   level;

    int checks = 0;
    int errors = 0;

    // Reference model: captured data queue plus handshake bookkeeping.
    logic [7:0] m_q[$];
    bit         m_ack, m_wait, m_sto, m_perr;
    int         m_stall, m_txn;

    always #5 clk = ~clk;

    hs_responder #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .txn_count     (txn_count),
        .stall_timeout (stall_timeout),
        .proto_err     (proto_err),
        .clr_err       (clr_err)
    );

    task automatic model_reset();
        m_q.delete();
        m_ack = 0; m_wait = 0; m_sto = 0; m_perr = 0; m_stall = 0; m_txn = 0;
    endtask

    // Advance the model with the inputs about to be sampled, then clock the DUT.
    task automatic cycle();
        bit pop, space;
        pop   = (m_q.size() > 0) && rsp_ready;
        space = (m_q.size() < DEPTH) || pop;
        if (clr_err) begin m_sto = 0; m_perr = 0; end
        if (pop) void'(m_q.pop_front());
        if (m_ack) begin
            if (!req) m_ack = 0;
        end else if (req && space) begin
            m_q.push_back(req_data);
            m_txn = (m_txn + 1) % 256;
            m_ack = 1; m_wait = 0; m_stall = 0;
        end else if (req) begin
            m_stall = m_wait ? ((m_stall + 1 > TO) ? TO : m_stall + 1) : 1;
            m_wait  = 1;
            if (m_stall >= TO) m_sto = 1;
        end else if (m_wait) begin
            m_perr = 1; m_wait = 0; m_stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 0; rsp_ready = 0; clr_err = 0; req_data = '0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic handshake(input logic [7:0] d);
        req = 1; req_data = d; cycle();
        req = 0; req_data = 8'($urandom); cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ack !== 1'b0)       begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", rsp_data); end
        checks++; if (txn_count !== 8'd0) begin errors++; $display("FAIL reset_txn: got %0d expected 0", txn_count); end
        checks++; if ({stall_timeout, proto_err} !== 2'b00)
            begin errors++; $display("FAIL reset_flags: got %b expected 00", {stall_timeout, proto_err}); end
    endtask

    task automatic test_basic();
        do_reset();
        req = 1; req_data = 8'hA5; cycle();
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL basic_ack_rise: got %0b expected 1", ack); end
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL basic_level: got %0d expected 1", level); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", rsp_valid); end
        checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0h expected a5", rsp_data); end
        checks++; if (txn_count !== 8'd1) begin errors++; $display("FAIL basic_txn: got %0d expected 1", txn_count); end
        req_data = 8'h3C; cycle(); cycle();
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL basic_ack_hold: got %0b expected 1", ack); end
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL basic_no_recapture: got %0d expected 1", level); end
        req = 0; cycle();
        checks++; if (ack !== 1'b0)       begin errors++; $display("FAIL basic_ack_fall: got %0b expected 0", ack); end
        rsp_ready = 1; cycle(); rsp_ready = 0;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL basic_drain: got %0b expected 1", empty); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int i = 1; i <= 4; i++) handshake(8'(i));
        checks++; if (full !== 1'b1)      begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL fill_level: got %0d expected 4", level); end
        checks++; if (rsp_data !== 8'd1)  begin errors++; $display("FAIL fill_head: got %0h expected 1", rsp_data); end
        req = 1; req_data = 8'd5; cycle();
        checks++; if (ack !== 1'b0)       begin errors++; $display("FAIL stall_ack: got %0b expected 0", ack); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL stall_early: got %0b expected 0", stall_timeout); end
        cycle();
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %0b expected 1", stall_timeout); end
        rsp_ready = 1; cycle(); rsp_ready = 0;
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL stall_swap_level: got %0d expected 4", level); end
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL stall_release_ack: got %0b expected 1", ack); end
        checks++; if (rsp_data !== 8'd2)  begin errors++; $display("FAIL stall_head: got %0h expected 2", rsp_data); end
        checks++; if (txn_count !== 8'd5) begin errors++; $display("FAIL stall_txn: got %0d expected 5", txn_count); end
        req = 0; cycle();
    endtask

    task automatic test_simul();
        do_reset();
        handshake(8'h11); handshake(8'h22);
        req = 1; req_data = 8'h33; rsp_ready = 1; cycle();
        req = 0; rsp_ready = 0;
        checks++; if (level !== 3'd2)     begin errors++; $display("FAIL simul_level: got %0d expected 2", level); end
        checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL simul_head: got %0h expected 22", rsp_data); end
        checks++; if (txn_count !== 8'd3) begin errors++; $display("FAIL simul_txn: got %0d expected 3", txn_count); end
        cycle();
    endtask

    task automatic test_withdraw();
        do_reset();
        for (int i = 0; i < 4; i++) handshake(8'(8'h40 + i));
        req = 1; req_data = 8'h99; cycle();
        req = 0; cycle();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wd_perr: got %0b expected 1", proto_err); end
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL wd_level: got %0d expected 4", level); end
        checks++; if (txn_count !== 8'd4) begin errors++; $display("FAIL wd_txn: got %0d expected 4", txn_count); end
        clr_err = 1; cycle(); clr_err = 0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b expected 0", proto_err); end
        rsp_ready = 1; cycle(); rsp_ready = 0;
        req = 1; req_data = 8'hC3; cycle();
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL wd_idle_ack: got %0b expected 1", ack); end
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL wd_refill: got %0d expected 4", level); end
        req = 0; cycle();
        req = 1; req_data = 8'h5F; cycle();
        req = 0; clr_err = 1; cycle(); clr_err = 0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wd_set_wins: got %0b expected 1", proto_err); end
    endtask

    task automatic test_wrap();
        bit saw_full = 0;
        do_reset();
        rsp_ready = 1;
        for (int i = 0; i < 300; i++) begin
            req = 1; req_data = 8'($urandom); cycle();
            checks++;
            if (rsp_data !== (m_q.size() > 0 ? m_q[0] : 8'h00))
                begin errors++; $display("FAIL wrap_order %0d: got %0h expected %0h", i, rsp_data, req_data); end
            if (full === 1'b1) saw_full = 1;
            req = 0; cycle();
            if (full === 1'b1) saw_full = 1;
        end
        rsp_ready = 0;
        checks++; if (txn_count !== 8'd44) begin errors++; $display("FAIL wrap_txn: got %0d expected 44", txn_count); end
        checks++; if (saw_full)            begin errors++; $display("FAIL wrap_full: got 1 expected 0"); end
        checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        handshake(8'h01); handshake(8'h02);
        req = 1; req_data = 8'h77; cycle();
        checks++; if ({ack, level} !== {1'b1, 3'd3})
            begin errors++; $display("FAIL areset_pre: got %b expected 1011", {ack, level}); end
        #2 rst_n = 0;
        #1;
        checks++; if ({ack, level, empty, full, rsp_valid} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0})
            begin errors++; $display("FAIL areset_ctrl: got %b expected 0000100", {ack, level, empty, full, rsp_valid}); end
        checks++; if ({rsp_data, txn_count, stall_timeout, proto_err} !== 18'd0)
            begin errors++; $display("FAIL areset_data: got %h expected 0", {rsp_data, txn_count, stall_timeout, proto_err}); end
        req = 0; rst_n = 1; model_reset();
        req = 1; req_data = 8'h5A; cycle();
        checks++; if ({ack, level} !== {1'b1, 3'd1})
            begin errors++; $display("FAIL areset_post: got %b expected 1001", {ack, level}); end
        req = 0; cycle();
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req       = ($urandom_range(0, 99) < 60);
            req_data  = 8'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 40);
            clr_err   = ($urandom_range(0, 99) < 5);
            cycle();
            exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
            checks++; if (ack !== m_ack)
                begin errors++; $display("FAIL rand_ack cyc %0d: got %0b expected %0b", i, ack, m_ack); end
            checks++; if (level !== 3'(m_q.size()))
                begin errors++; $display("FAIL rand_level cyc %0d: got %0d expected %0d", i, level, m_q.size()); end
            checks++; if ({full, empty, rsp_valid} !== {m_q.size() == DEPTH, m_q.size() == 0, m_q.size() != 0})
                begin errors++; $display("FAIL rand_flags cyc %0d: got %b level %0d", i, {full, empty, rsp_valid}, m_q.size()); end
            checks++; if (rsp_data !== exp_data)
                begin errors++; $display("FAIL rand_data cyc %0d: got %0h expected %0h", i, rsp_data, exp_data); end
            checks++; if (txn_count !== 8'(m_txn))
                begin errors++; $display("FAIL rand_txn cyc %0d: got %0d expected %0d", i, txn_count, m_txn); end
            checks++; if ({stall_timeout, proto_err} !== {m_sto, m_perr})
                begin errors++; $display("FAIL rand_sticky cyc %0d: got %b expected %b", i, {stall_timeout, proto_err}, {m_sto, m_perr}); end
        end
        req = 0; rsp_ready = 0; clr_err = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_stall();
        test_simul();
        test_withdraw();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
